// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning the HI/LO registers.
// One shared 64-bit shift/add-subtract datapath, 32 iterations per operation.
module muldiv_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned W     = 32;
    localparam int unsigned CNT_W = 5;

    typedef enum logic [2:0] {
        S_IDLE, S_PREP, S_RUN, S_FIX, S_DONE
    } state_t;

    state_t             state, state_nx;
    logic [1:0]         op_r;
    logic [W-1:0]       a_r, b_r, mag_a, mag_b;
    logic               neg_res, neg_rem;
    logic [2*W-1:0]     acc;
    logic [CNT_W-1:0]   cnt;

    logic accept_c, load_c, prep_c, run_c, commit_c, busy_nx, done_nx;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    // Next-state logic; flush cancels anything in flight, including FIX
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (start) state_nx = S_PREP;
            S_PREP: state_nx = flush ? S_IDLE : S_RUN;
            S_RUN: begin
                if (flush)                    state_nx = S_IDLE;
                else if (cnt == CNT_W'(0))    state_nx = S_FIX;
            end
            S_FIX:  state_nx = flush ? S_IDLE : S_DONE;
            S_DONE: state_nx = start ? S_PREP : S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        accept_c = (state == S_IDLE) || (state == S_DONE);
        load_c   = accept_c && start;
        prep_c   = (state == S_PREP);
        run_c    = (state == S_RUN);
        commit_c = (state == S_FIX) && !flush;
        busy_nx  = (state_nx == S_PREP) || (state_nx == S_RUN) || (state_nx == S_FIX);
        done_nx  = (state_nx == S_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= busy_nx;
            done <= done_nx;
        end
    end

    // Operand magnitudes and result signs from the latched operands
    logic         signed_op, a_neg, b_neg, is_div, div_zero;
    logic [W-1:0] mag_a_c, mag_b_c;

    always_comb begin
        signed_op = ~op_r[0];
        is_div    = op_r[1];
        a_neg     = signed_op & a_r[W-1];
        b_neg     = signed_op & b_r[W-1];
        mag_a_c   = a_neg ? W'(-a_r) : a_r;
        mag_b_c   = b_neg ? W'(-b_r) : b_r;
        div_zero  = (b_r == W'(0));
    end

    // One iteration: shift-add for multiply, restoring step for divide
    logic [W:0]     mul_sum;
    logic           div_ok;
    logic [W-1:0]   div_diff;
    logic [2*W-1:0] step_c;

    always_comb begin
        mul_sum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, mag_a} : (W+1)'(0));
        div_ok   = acc[2*W-1:W-1] >= {1'b0, mag_b};
        div_diff = acc[2*W-2:W-1] - mag_b;
        if (is_div)
            step_c = div_ok ? {div_diff, acc[W-2:0], 1'b1} : {acc[2*W-2:0], 1'b0};
        else
            step_c = {mul_sum, acc[W-1:1]};
    end

    // Sign correction of the finished accumulator
    logic [2*W-1:0] prod_c;
    logic [W-1:0]   fix_hi, fix_lo;

    always_comb begin
        prod_c = neg_res ? (2*W)'(-acc) : acc;
        if (is_div && div_zero) begin
            fix_hi = a_r;
            fix_lo = '1;
        end else if (is_div) begin
            fix_lo = neg_res ? W'(-acc[W-1:0]) : acc[W-1:0];
            fix_hi = neg_rem ? W'(-acc[2*W-1:W]) : acc[2*W-1:W];
        end else begin
            fix_hi = prod_c[2*W-1:W];
            fix_lo = prod_c[W-1:0];
        end
    end

    // Working registers and architectural HI/LO
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_r    <= '0;
            a_r     <= '0;
            b_r     <= '0;
            mag_a   <= '0;
            mag_b   <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            acc     <= '0;
            cnt     <= '0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            if (load_c) begin
                op_r <= op;
                a_r  <= a;
                b_r  <= b;
            end
            if (prep_c) begin
                mag_a   <= mag_a_c;
                mag_b   <= mag_b_c;
                neg_res <= a_neg ^ b_neg;
                neg_rem <= a_neg;
                acc     <= {W'(0), is_div ? mag_a_c : mag_b_c};
                cnt     <= CNT_W'(31);
            end
            if (run_c) begin
                acc <= step_c;
                cnt <= CNT_W'(cnt - CNT_W'(1));
            end
            if (commit_c) begin
                hi <= fix_hi;
                lo <= fix_lo;
            end else if (accept_c) begin
                if (hi_we) hi <= wdata;
                if (lo_we) lo <= wdata;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer.
`timescale 1ns/1ps
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        flush, hi_we, lo_we;
    logic [31:0] wdata;
    logic        busy, done;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] MULT = 2'd0, MULTU = 2'd1, DIV = 2'd2, DIVU = 2'd3;

    muldiv_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1; op = o; a = x; b = y;
        tick();
        start = 1'b0;
    endtask

    // Edges from the start edge until done is seen; busy must stay high meanwhile
    task automatic wait_done(output int lat, output logic busy_ok);
        lat = 0;
        busy_ok = 1'b1;
        while (done !== 1'b1 && lat < 60) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            tick();
            lat++;
        end
    endtask

    int   lat;
    logic bok;
    logic seen;

    initial begin
        reset = 1'b1; start = 1'b0; op = 2'd0; a = '0; b = '0;
        flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        #12;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        reset = 1'b0;
        tick();

        // MULTU max * max
        start_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu_busy_after_start", {31'd0, busy}, 32'd1);
        wait_done(lat, bok);
        check("multu_latency", lat, 32'd34);
        check("multu_busy_held", {31'd0, bok}, 32'd1);
        check("multu_busy_at_done", {31'd0, busy}, 32'd0);
        check("multu_hi", hi, 32'hFFFF_FFFE);
        check("multu_lo", lo, 32'h0000_0001);
        tick();
        check("done_one_cycle", {31'd0, done}, 32'd0);
        check("multu_hi_held", hi, 32'hFFFF_FFFE);

        // MULT -3 * 5, then DIV -7 / 2 started in the DONE cycle
        start_op(MULT, 32'hFFFF_FFFD, 32'd5);
        wait_done(lat, bok);
        check("mult_latency", lat, 32'd34);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFF1);
        start_op(DIV, 32'hFFFF_FFF9, 32'd2);
        check("b2b_busy", {31'd0, busy}, 32'd1);
        check("b2b_done_low", {31'd0, done}, 32'd0);
        wait_done(lat, bok);
        check("div_latency", lat, 32'd34);
        check("div_busy_held", {31'd0, bok}, 32'd1);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);

        // DIVU by zero, then signed overflow divide
        start_op(DIVU, 32'd100, 32'd0);
        wait_done(lat, bok);
        check("divz_latency", lat, 32'd34);
        check("divz_hi", hi, 32'h0000_0064);
        check("divz_lo", lo, 32'hFFFF_FFFF);
        start_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(lat, bok);
        check("divovf_lo", lo, 32'h8000_0000);
        check("divovf_hi", hi, 32'h0000_0000);
        tick();

        // MTHI preload, then flush in RUN cycle 10
        hi_we = 1'b1; wdata = 32'h11;
        tick();
        hi_we = 1'b0;
        check("mthi", hi, 32'h11);
        start_op(MULTU, 32'd3, 32'd4);
        tick(); tick();
        hi_we = 1'b1; wdata = 32'h99;
        tick();
        hi_we = 1'b0;
        check("mthi_busy_ignored", hi, 32'h11);
        repeat (7) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_busy", {31'd0, busy}, 32'd0);
        check("flush_done", {31'd0, done}, 32'd0);
        seen = 1'b0;
        repeat (40) begin
            tick();
            if (done === 1'b1) seen = 1'b1;
        end
        check("flush_no_done", {31'd0, seen}, 32'd0);
        check("flush_hi", hi, 32'h11);
        check("flush_lo", lo, 32'h8000_0000);

        // MTLO in the start cycle, then start while busy is ignored
        lo_we = 1'b1; wdata = 32'h55;
        start_op(MULTU, 32'd3, 32'd4);
        lo_we = 1'b0;
        check("mtlo_with_start", lo, 32'h55);
        repeat (5) tick();
        start_op(MULTU, 32'd7, 32'd7);
        wait_done(lat, bok);
        check("ignore_latency", lat, 32'd28);
        check("ignore_lo", lo, 32'd12);
        check("ignore_hi", hi, 32'd0);
        tick();
        check("ignore_not_queued", {31'd0, busy}, 32'd0);

        // Async reset mid-RUN
        hi_we = 1'b1; wdata = 32'hAB;
        tick();
        hi_we = 1'b0;
        check("pre_reset_hi", hi, 32'hAB);
        start_op(MULTU, 32'd6, 32'd7);
        repeat (5) tick();
        #3 reset = 1'b1;
        #1;
        check("areset_busy", {31'd0, busy}, 32'd0);
        check("areset_hi", hi, 32'd0);
        check("areset_lo", lo, 32'd0);
        reset = 1'b0;
        repeat (40) tick();
        check("areset_stays_idle", {31'd0, busy | done}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
